mux_n_reg: RTL and testbench

- Parametrised N-way, WIDTH-bit selector with a registered output stage and valid/ready handshake.
- Generalises the combinational 4:1 operand mux used in the multicycle datapath.
- Two selection modes: explicit select, or an auto-rotating select pointer that steps through channels on each accepted transfer.
- Sits between register-file/immediate sources and the ALU/memory-address stage wherever a selected operand must be held across stall cycles.

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_n_comb.sv | 36 +++
 rtl/mux_n_reg.sv | 106 ++++++++++
 tb/tb_mux_n_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared types and default sizing for the N-way operand selector.
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic {
        MODE_EXPLICIT = 1'b0,
        MODE_ROTATE   = 1'b1
    } mux_mode_e;

    localparam int MUX_DEFAULT_WIDTH = 64;
    localparam int MUX_DEFAULT_N     = 4;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_n_comb.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_comb
// Brief    : Purely combinational N:1 selector; out-of-range selects fall
//            back to channel 0 and are reported through sel_ok.
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEFAULT_WIDTH,
    parameter int N     = MUX_DEFAULT_N,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               sel_ok
);

    localparam logic [SEL_W:0] c_N = (SEL_W + 1)'(N);

    assign sel_ok = ({1'b0, sel} < c_N);

    // Channel 0 is the default, which also covers unreachable select codes.
    always_comb begin
        out_data = in_data[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule : mux_n_comb
`default_nettype wire

// File: rtl/mux_n_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_reg
// Brief    : N-way WIDTH-bit selector with a single-entry registered output,
//            valid/ready handshake and an auto-rotating select pointer.
//            Macro MUX_SEL_CHECK_EN adds a sticky sel_err output.
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEFAULT_WIDTH,
    parameter int N     = MUX_DEFAULT_N,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   rr_ptr
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic               sel_err
`endif
);

    localparam logic [SEL_W-1:0] c_LAST = SEL_W'(N - 1);

    mux_mode_e          w_mode;
    logic [SEL_W-1:0]   w_eff;
    logic [SEL_W-1:0]   w_eff_sel;
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_ok;
    logic               w_in_ready;
    logic               w_accept;

    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic               r_out_valid;
    logic [SEL_W-1:0]   r_rr_ptr;

    assign w_mode     = mux_mode_e'(mode);
    assign w_eff      = (w_mode == MODE_ROTATE) ? r_rr_ptr : sel;
    assign w_eff_sel  = w_sel_ok ? w_eff : '0;
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_mux_n_comb (
        .in_data  (in_data),
        .sel      (w_eff),
        .out_data (w_sel_data),
        .sel_ok   (w_sel_ok)
    );

    // A fresh accept wins over delivery so back-to-back transfers keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_eff_sel;
            r_out_valid <= 1'b1;
            if (w_mode == MODE_ROTATE) begin
                r_rr_ptr <= (r_rr_ptr == c_LAST) ? '0 : r_rr_ptr + 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic r_sel_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && (w_mode == MODE_EXPLICIT) && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign rr_ptr    = r_rr_ptr;

endmodule : mux_n_reg
`default_nettype wire

// File: tb/tb_mux_n_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_n_reg
// Brief    : Self-checking bench for mux_n_reg (N=4 x 64b and N=3 x 8b).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_n_reg;

    logic          clk = 1'b0;
    logic          rst_n;

    // N=4, WIDTH=64 instance
    logic          mode, in_valid, out_ready;
    logic [1:0]    sel;
    logic [255:0]  in_data;
    logic          in_ready, out_valid;
    logic [63:0]   out_data;
    logic [1:0]    out_sel, rr_ptr;

    // N=3, WIDTH=8 instance
    logic          mode3, in_valid3, out_ready3;
    logic [1:0]    sel3;
    logic [23:0]   in_data3;
    logic          in_ready3, out_valid3;
    logic [7:0]    out_data3;
    logic [1:0]    out_sel3, rr_ptr3;
`ifdef MUX_SEL_CHECK_EN
    logic          sel_err, sel_err3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_n_reg #(.WIDTH(64), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .rr_ptr(rr_ptr)
`ifdef MUX_SEL_CHECK_EN
        , .sel_err(sel_err)
`endif
    );

    mux_n_reg #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
        .rr_ptr(rr_ptr3)
`ifdef MUX_SEL_CHECK_EN
        , .sel_err(sel_err3)
`endif
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [63:0] exp_data;
        logic [1:0]  exp_sel;
        logic [1:0]  exp_ptr;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] pack4(input logic [63:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Reference model state for the randomized phase
    logic [63:0] m_data;
    int          m_sel, m_ptr;
    logic        m_valid;
    logic [63:0] ch[4];

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        mode = 1'b0; sel = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;

        // Explicit 0..3, six rotating accepts, then explicit sel=3.
        for (int i = 0; i < 4; i++)
            tbl[i] = '{1'b0, 2'(i), 64'(13 + i), 2'(i), 2'd0};
        for (int i = 0; i < 6; i++)
            tbl[4 + i] = '{1'b1, 2'd0, 64'(13 + (i % 4)), 2'(i % 4), 2'((i + 1) % 4)};
        tbl[10] = '{1'b0, 2'd3, 64'd16, 2'd3, 2'd2};

        #13;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_sel", out_sel, 0);
        check("reset_rr_ptr", rr_ptr, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        in_data = pack4(64'd13, 64'd14, 64'd15, 64'd16);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            mode = tbl[i].mode;
            sel  = tbl[i].sel;
            tick();
            check($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
            check($sformatf("tbl%0d_sel", i), out_sel, tbl[i].exp_sel);
            check($sformatf("tbl%0d_valid", i), out_valid, 1);
            check($sformatf("tbl%0d_ptr", i), rr_ptr, tbl[i].exp_ptr);
        end

        // Stall / hold
        mode = 1'b0; sel = 2'd2;
        tick();
        check("stall_load", out_data, 15);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = 2'($urandom_range(0, 3));
            in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            check($sformatf("stall%0d_in_ready", i), in_ready, 0);
            tick();
            check($sformatf("stall%0d_data", i), out_data, 15);
            check($sformatf("stall%0d_sel", i), out_sel, 2);
            check($sformatf("stall%0d_valid", i), out_valid, 1);
            check($sformatf("stall%0d_ptr", i), rr_ptr, 2);
        end
        out_ready = 1'b1;
        sel = 2'd0;
        in_data = pack4(64'd13, 64'd14, 64'd15, 64'd16);
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        check("release_data", out_data, 13);
        check("release_valid", out_valid, 1);

        // Reset while stalled
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("prerst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_ptr", rr_ptr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b0; sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("postrst_data", out_data, 14);
        check("postrst_sel", out_sel, 1);

        // Out-of-range select on the N=3 instance
        in_valid = 1'b0;
        do_reset();
`ifdef MUX_SEL_CHECK_EN
        check("oob_err_init", sel_err3, 0);
`endif
        in_data3 = {8'd9, 8'd8, 8'd7};
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
        tick();
        check("oob_data", out_data3, 7);
        check("oob_sel", out_sel3, 0);
        check("oob_valid", out_valid3, 1);
`ifdef MUX_SEL_CHECK_EN
        check("oob_err_set", sel_err3, 1);
`endif
        sel3 = 2'd2;
        tick();
        check("oob_next_data", out_data3, 9);
        check("oob_next_sel", out_sel3, 2);
        sel3 = 2'd1;
        tick();
        check("oob_next2_data", out_data3, 8);
`ifdef MUX_SEL_CHECK_EN
        check("oob_err_sticky", sel_err3, 1);
`endif
        in_valid3 = 1'b0;
        do_reset();
`ifdef MUX_SEL_CHECK_EN
        check("oob_err_cleared", sel_err3, 0);
`endif

        // Randomized traffic against the behavioural model
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 4; k++) ch[k] = {$urandom, $urandom};
            in_data   = pack4(ch[0], ch[1], ch[2], ch[3]);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check("rnd_in_ready", in_ready, (!m_valid || out_ready));
            if (in_valid && (!m_valid || out_ready)) begin
                m_sel   = mode ? m_ptr : int'(sel);
                m_data  = ch[m_sel];
                m_valid = 1'b1;
                if (mode) m_ptr = (m_ptr + 1) % 4;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            tick();
            check("rnd_valid", out_valid, m_valid);
            check("rnd_data", out_data, m_data);
            check("rnd_sel", out_sel, 64'(m_sel));
            check("rnd_ptr", rr_ptr, 64'(m_ptr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux_n_reg
`default_nettype wire
